// File: rtl/nvme_queue_ctrl_pkg.sv
// Shared constants, CQE field layout and doorbell FSM encoding for the
// NVMe I/O queue-pair controller.
package nvme_drv_pkg;

  localparam int          OUTSTANDING = 16;
  localparam logic [31:0] DB_BASE     = 32'h1000;
  localparam int          DSTRD       = 0;

  localparam int CQE_SQHD_LSB = 64;
  localparam int CQE_CID_LSB  = 96;
  localparam int CQE_P_BIT    = 112;
  localparam int CQE_STS_LSB  = 113;

  typedef enum logic [1:0] {
    DB_IDLE  = 2'd0,
    DB_ISSUE = 2'd1,
    DB_RESP  = 2'd2
  } db_state_e;

  // SQ doorbell of queue pair q sits at slot 2q, its CQ doorbell at 2q+1.
  function automatic logic [31:0] db_addr(logic [31:0] base, int qid, int dstrd, logic is_cq);
    return base + 32'(((2 * qid) + int'(is_cq)) << (2 + dstrd));
  endfunction

endpackage

// File: rtl/nvme_queue_ctrl_if.sv
// AXI-Lite write-only channel set used to ring NVMe doorbells.
interface nvme_queue_ctrl_if;
  logic [31:0] nl_awaddr;
  logic        nl_awvalid;
  logic        nl_awready;
  logic [31:0] nl_wdata;
  logic [3:0]  nl_wstrb;
  logic        nl_wvalid;
  logic        nl_wready;
  logic [1:0]  nl_bresp;
  logic        nl_bvalid;
  logic        nl_bready;

  modport master (
    output nl_awaddr, nl_awvalid, nl_wdata, nl_wstrb, nl_wvalid, nl_bready,
    input  nl_awready, nl_wready, nl_bresp, nl_bvalid
  );

  modport slave (
    input  nl_awaddr, nl_awvalid, nl_wdata, nl_wstrb, nl_wvalid, nl_bready,
    output nl_awready, nl_wready, nl_bresp, nl_bvalid
  );
endinterface

// File: rtl/nvme_queue_ctrl_db_axil_writer.sv
// Single-outstanding AXI-Lite doorbell writer: AW and W issued together,
// each retired on its own handshake, then one B response collected.
//
// state    | meaning
// DB_IDLE  | waiting for start_i; payload latched on start
// DB_ISSUE | AW and/or W still valid, waiting for handshakes
// DB_RESP  | bready high, waiting for the write response
module nvme_db_axil_writer
  import nvme_drv_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  nvme_queue_ctrl_if.master nl
);

  db_state_e   state_q;
  logic        awvalid_q, wvalid_q, bready_q;
  logic [31:0] awaddr_q, wdata_q;
  logic        done_q, err_q;
  logic        aw_fire, w_fire;

  assign aw_fire = awvalid_q & nl.nl_awready;
  assign w_fire  = wvalid_q & nl.nl_wready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= DB_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (start_i) begin
            awaddr_q  <= addr_i;
            wdata_q   <= data_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= DB_ISSUE;
          end
        end
        DB_ISSUE: begin
          if (aw_fire) awvalid_q <= 1'b0;
          if (w_fire)  wvalid_q  <= 1'b0;
          // A channel that already retired counts as complete this cycle.
          if ((!awvalid_q || aw_fire) && (!wvalid_q || w_fire)) begin
            bready_q <= 1'b1;
            state_q  <= DB_RESP;
          end
        end
        DB_RESP: begin
          if (nl.nl_bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= (nl.nl_bresp != 2'b00);
            state_q  <= DB_IDLE;
          end
        end
        default: state_q <= DB_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != DB_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign nl.nl_awaddr  = awaddr_q;
  assign nl.nl_awvalid = awvalid_q;
  assign nl.nl_wdata   = wdata_q;
  assign nl.nl_wstrb   = 4'hF;
  assign nl.nl_wvalid  = wvalid_q;
  assign nl.nl_bready  = bready_q;

endmodule

// File: rtl/nvme_queue_ctrl.sv
// NVMe I/O queue-pair controller: SQ/CQ pointer tracking, phase checking,
// completion reporting and coalesced doorbell writes.
module nvme_queue_ctrl
  import nvme_drv_pkg::*;
#(
  parameter int          OUTSTANDING = nvme_drv_pkg::OUTSTANDING,
  parameter int          QID         = 1,
  parameter logic [31:0] DB_BASE     = nvme_drv_pkg::DB_BASE,
  parameter int          DSTRD       = nvme_drv_pkg::DSTRD
)(
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           sq_commit_valid,
  output logic                           sq_commit_ready,
  output logic [$clog2(OUTSTANDING)-1:0] sq_tail,
  output logic [$clog2(OUTSTANDING)-1:0] sq_head,
  output logic                           sq_full,
  output logic [$clog2(OUTSTANDING):0]   inflight,
  input  logic                           cqe_valid,
  input  logic [127:0]                   cqe_data,
  output logic                           cqe_ready,
  output logic                           cpl_valid,
  output logic [15:0]                    cpl_cid,
  output logic [14:0]                    cpl_status,
  nvme_queue_ctrl_if.master              nl,
  output logic                           err_stale,
  output logic                           err_sqhd,
  output logic                           err_bresp
);

  localparam int          PW         = $clog2(OUTSTANDING);
  localparam logic [31:0] SQ_DB_ADDR = db_addr(DB_BASE, QID, DSTRD, 1'b0);
  localparam logic [31:0] CQ_DB_ADDR = db_addr(DB_BASE, QID, DSTRD, 1'b1);

  logic [PW-1:0] sq_tail_q, sq_tail_d, sq_head_q, sq_head_d, cq_head_q, cq_head_d;
  logic [PW:0]   inflight_q, inflight_d;
  logic          exp_phase_q, exp_phase_d;
  logic          sq_pend_q, sq_pend_d, cq_pend_q, cq_pend_d, last_sq_q, last_sq_d;
  logic          err_stale_q, err_stale_d, err_sqhd_q, err_sqhd_d, err_bresp_q, err_bresp_d;
  logic          cpl_valid_q, cpl_valid_d;
  logic [15:0]   cpl_cid_q, cpl_cid_d;
  logic [14:0]   cpl_status_q, cpl_status_d;

  logic          commit, cqe_ok, cqe_stale, sqhd_bad;
  logic [PW-1:0] cqe_sqhd;
  logic          wr_busy, wr_done, wr_err, db_start, sel_sq;
  logic [31:0]   sel_addr, sel_data;
  logic          unused_cqe_bits;

  assign sq_full  = ((sq_tail_q + 1'b1) == sq_head_q);
  assign commit   = sq_commit_valid & ~sq_full;
  assign cqe_sqhd = cqe_data[CQE_SQHD_LSB +: PW];
  assign cqe_ok    = cqe_valid & (cqe_data[CQE_P_BIT] == exp_phase_q);
  assign cqe_stale = cqe_valid & (cqe_data[CQE_P_BIT] != exp_phase_q);
  // Offset from head must not exceed the head-to-tail span, modulo depth.
  assign sqhd_bad  = (PW'(cqe_sqhd - sq_head_q) > PW'(sq_tail_q - sq_head_q));
  assign unused_cqe_bits = ^{cqe_data[CQE_SQHD_LSB-1:0], cqe_data[CQE_CID_LSB-1:CQE_SQHD_LSB+PW]};

  // Arbitration alternates when both doorbells are pending.
  assign sel_sq   = sq_pend_q & (~cq_pend_q | ~last_sq_q);
  assign db_start = ~wr_busy & (sq_pend_q | cq_pend_q);
  assign sel_addr = sel_sq ? SQ_DB_ADDR : CQ_DB_ADDR;
  assign sel_data = sel_sq ? 32'(sq_tail_q) : 32'(cq_head_q);

  always_comb begin
    sq_tail_d    = sq_tail_q;
    sq_head_d    = sq_head_q;
    cq_head_d    = cq_head_q;
    inflight_d   = inflight_q;
    exp_phase_d  = exp_phase_q;
    last_sq_d    = last_sq_q;
    err_stale_d  = err_stale_q | cqe_stale;
    err_sqhd_d   = err_sqhd_q;
    err_bresp_d  = err_bresp_q | (wr_done & wr_err);
    cpl_valid_d  = cqe_ok;
    cpl_cid_d    = cpl_cid_q;
    cpl_status_d = cpl_status_q;
    sq_pend_d    = sq_pend_q & ~(db_start & sel_sq);
    cq_pend_d    = cq_pend_q & ~(db_start & ~sel_sq);

    if (db_start) last_sq_d = sel_sq;

    if (commit) begin
      sq_tail_d = sq_tail_q + 1'b1;
      sq_pend_d = 1'b1;
    end

    if (cqe_ok) begin
      cpl_cid_d    = cqe_data[CQE_CID_LSB +: 16];
      cpl_status_d = cqe_data[CQE_STS_LSB +: 15];
      cq_head_d    = cq_head_q + 1'b1;
      cq_pend_d    = 1'b1;
      sq_head_d    = cqe_sqhd;
      err_sqhd_d   = err_sqhd_q | sqhd_bad;
      if (&cq_head_q) exp_phase_d = ~exp_phase_q;
    end

    case ({commit, cqe_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sq_tail_q    <= '0;
      sq_head_q    <= '0;
      cq_head_q    <= '0;
      inflight_q   <= '0;
      exp_phase_q  <= 1'b1;
      sq_pend_q    <= 1'b0;
      cq_pend_q    <= 1'b0;
      last_sq_q    <= 1'b0;
      err_stale_q  <= 1'b0;
      err_sqhd_q   <= 1'b0;
      err_bresp_q  <= 1'b0;
      cpl_valid_q  <= 1'b0;
      cpl_cid_q    <= '0;
      cpl_status_q <= '0;
    end else begin
      sq_tail_q    <= sq_tail_d;
      sq_head_q    <= sq_head_d;
      cq_head_q    <= cq_head_d;
      inflight_q   <= inflight_d;
      exp_phase_q  <= exp_phase_d;
      sq_pend_q    <= sq_pend_d;
      cq_pend_q    <= cq_pend_d;
      last_sq_q    <= last_sq_d;
      err_stale_q  <= err_stale_d;
      err_sqhd_q   <= err_sqhd_d;
      err_bresp_q  <= err_bresp_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_cid_q    <= cpl_cid_d;
      cpl_status_q <= cpl_status_d;
    end
  end

  nvme_db_axil_writer u_db_wr (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (db_start),
    .addr_i  (sel_addr),
    .data_i  (sel_data),
    .busy_o  (wr_busy),
    .done_o  (wr_done),
    .err_o   (wr_err),
    .nl      (nl)
  );

  assign sq_commit_ready = ~sq_full;
  assign sq_tail         = sq_tail_q;
  assign sq_head         = sq_head_q;
  assign inflight        = inflight_q;
  assign cqe_ready       = rstn;
  assign cpl_valid       = cpl_valid_q;
  assign cpl_cid         = cpl_cid_q;
  assign cpl_status      = cpl_status_q;
  assign err_stale       = err_stale_q;
  assign err_sqhd        = err_sqhd_q;
  assign err_bresp       = err_bresp_q;

endmodule

// File: tb/tb_nvme_queue_ctrl.sv
// Directed bench for nvme_queue_ctrl: vector table for pointer/completion
// behaviour plus sequences for doorbell, wrap, stall and reset corners.
module tb_nvme_queue_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         sq_commit_valid, sq_commit_ready, sq_full;
  logic [3:0]   sq_tail, sq_head;
  logic [4:0]   inflight;
  logic         cqe_valid, cqe_ready, cpl_valid;
  logic [127:0] cqe_data;
  logic [15:0]  cpl_cid;
  logic [14:0]  cpl_status;
  logic         err_stale, err_sqhd, err_bresp;

  nvme_queue_ctrl_if nl_if ();

  nvme_queue_ctrl dut (
    .clk(clk), .rstn(rstn),
    .sq_commit_valid(sq_commit_valid), .sq_commit_ready(sq_commit_ready),
    .sq_tail(sq_tail), .sq_head(sq_head), .sq_full(sq_full), .inflight(inflight),
    .cqe_valid(cqe_valid), .cqe_data(cqe_data), .cqe_ready(cqe_ready),
    .cpl_valid(cpl_valid), .cpl_cid(cpl_cid), .cpl_status(cpl_status),
    .nl(nl_if),
    .err_stale(err_stale), .err_sqhd(err_sqhd), .err_bresp(err_bresp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // AXI-Lite slave model and write log
  int          aw_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        b_en = 1'b1;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [3:0]  wr_strb[$];

  initial begin
    logic        p_awv, p_wv, p_brdy, aw_seen, w_seen, b_pend;
    logic [31:0] p_awaddr, p_wdata, aw_addr, w_data;
    logic [3:0]  p_wstrb, w_strb;
    int          aw_wait;
    p_awv = 0; p_wv = 0; p_brdy = 0; aw_seen = 0; w_seen = 0; b_pend = 0;
    p_awaddr = '0; p_wdata = '0; aw_addr = '0; w_data = '0; p_wstrb = '0; w_strb = '0;
    aw_wait = 0;
    nl_if.nl_awready = 0; nl_if.nl_wready = 0; nl_if.nl_bvalid = 0; nl_if.nl_bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        aw_seen = 0; w_seen = 0; b_pend = 0; aw_wait = 0;
        nl_if.nl_awready = 0; nl_if.nl_wready = 0; nl_if.nl_bvalid = 0; nl_if.nl_bresp = 2'b00;
      end else begin
        if (p_awv && nl_if.nl_awready) begin aw_seen = 1; aw_addr = p_awaddr; end
        if (p_wv && nl_if.nl_wready) begin w_seen = 1; w_data = p_wdata; w_strb = p_wstrb; end
        if (nl_if.nl_bvalid && p_brdy) nl_if.nl_bvalid = 0;
        if (aw_seen && w_seen) begin
          wr_addr.push_back(aw_addr); wr_data.push_back(w_data); wr_strb.push_back(w_strb);
          aw_seen = 0; w_seen = 0; b_pend = 1;
        end
        if (b_pend && b_en && !nl_if.nl_bvalid) begin
          nl_if.nl_bvalid = 1; nl_if.nl_bresp = bresp_cfg; b_pend = 0;
        end
        if (nl_if.nl_awvalid && !aw_seen) begin
          nl_if.nl_awready = (aw_wait >= aw_delay);
          aw_wait++;
        end else begin
          nl_if.nl_awready = 0; aw_wait = 0;
        end
        nl_if.nl_wready = nl_if.nl_wvalid && !w_seen;
      end
      p_awv = nl_if.nl_awvalid; p_awaddr = nl_if.nl_awaddr;
      p_wv = nl_if.nl_wvalid; p_wdata = nl_if.nl_wdata; p_wstrb = nl_if.nl_wstrb;
      p_brdy = nl_if.nl_bready;
    end
  end

  function automatic logic [127:0] mk_cqe(logic p, logic [15:0] sqhd, logic [15:0] cid, logic [14:0] st);
    logic [127:0] d;
    d = '0;
    d[79:64]   = sqhd;
    d[111:96]  = cid;
    d[112]     = p;
    d[127:113] = st;
    return d;
  endfunction

  // One clock with the given inputs; returns #1 after the edge with inputs idle.
  task automatic cyc(input logic cm, input logic cv, input logic p,
                     input logic [15:0] sqhd, input logic [15:0] cid, input logic [14:0] st);
    @(negedge clk);
    sq_commit_valid = cm;
    cqe_valid       = cv;
    cqe_data        = mk_cqe(p, sqhd, cid, st);
    @(posedge clk); #1;
    sq_commit_valid = 0;
    cqe_valid       = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; sq_commit_valid = 0; cqe_valid = 0; cqe_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    wr_addr.delete(); wr_data.delete(); wr_strb.delete();
  endtask

  task automatic settle();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 8; i++) begin
      @(posedge clk); #1;
      if (!nl_if.nl_awvalid && !nl_if.nl_wvalid && !nl_if.nl_bready) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) begin
      n_cmp++; n_err++;
      $display("FAIL settle_timeout: doorbell bus still busy after 400 cycles, expected idle");
    end
  endtask

  typedef struct {
    logic        cm, cv, p;
    logic [15:0] sqhd, cid;
    logic [14:0] st;
    logic [3:0]  e_tail, e_head;
    logic [4:0]  e_infl;
    logic        e_full, e_cpl;
    logic [15:0] e_cid;
    logic [14:0] e_st;
    logic        e_stale, e_sqhd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0, 0, 16'd0, 16'd0, 15'd0,    4'd1, 4'd0, 5'd1, 0, 0, 16'd0, 15'd0,    0, 0};
    vecs[1] = '{1, 0, 0, 16'd0, 16'd0, 15'd0,    4'd2, 4'd0, 5'd2, 0, 0, 16'd0, 15'd0,    0, 0};
    vecs[2] = '{1, 0, 0, 16'd0, 16'd0, 15'd0,    4'd3, 4'd0, 5'd3, 0, 0, 16'd0, 15'd0,    0, 0};
    vecs[3] = '{0, 1, 1, 16'd1, 16'd0, 15'd0,    4'd3, 4'd1, 5'd2, 0, 1, 16'd0, 15'd0,    0, 0};
    vecs[4] = '{1, 1, 1, 16'd2, 16'd1, 15'h55,   4'd4, 4'd2, 5'd2, 0, 1, 16'd1, 15'h55,   0, 0};
    vecs[5] = '{0, 1, 0, 16'd3, 16'd7, 15'h11,   4'd4, 4'd2, 5'd2, 0, 0, 16'd0, 15'd0,    1, 0};
    vecs[6] = '{0, 1, 1, 16'd9, 16'd2, 15'h3,    4'd4, 4'd9, 5'd1, 0, 1, 16'd2, 15'h3,    1, 1};
    vecs[7] = '{0, 0, 0, 16'd0, 16'd0, 15'd0,    4'd4, 4'd9, 5'd1, 0, 0, 16'd0, 15'd0,    1, 1};

    rstn = 0; sq_commit_valid = 0; cqe_valid = 0; cqe_data = '0;
    do_reset();
    @(posedge clk); #1;
    chk("rst_sq_tail", 32'(sq_tail), 0);
    chk("rst_sq_head", 32'(sq_head), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_cpl_valid", 32'(cpl_valid), 0);
    chk("rst_errs", 32'({err_stale, err_sqhd, err_bresp}), 0);
    chk("rst_commit_ready", 32'(sq_commit_ready), 1);
    chk("rst_cqe_ready", 32'(cqe_ready), 1);
    chk("rst_awvalid", 32'(nl_if.nl_awvalid), 0);
    chk("rst_bready", 32'(nl_if.nl_bready), 0);

    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].cm, vecs[i].cv, vecs[i].p, vecs[i].sqhd, vecs[i].cid, vecs[i].st);
      chk($sformatf("v%0d_sq_tail", i), 32'(sq_tail), 32'(vecs[i].e_tail));
      chk($sformatf("v%0d_sq_head", i), 32'(sq_head), 32'(vecs[i].e_head));
      chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(vecs[i].e_infl));
      chk($sformatf("v%0d_sq_full", i), 32'(sq_full), 32'(vecs[i].e_full));
      chk($sformatf("v%0d_cpl_valid", i), 32'(cpl_valid), 32'(vecs[i].e_cpl));
      if (vecs[i].e_cpl) begin
        chk($sformatf("v%0d_cpl_cid", i), 32'(cpl_cid), 32'(vecs[i].e_cid));
        chk($sformatf("v%0d_cpl_status", i), 32'(cpl_status), 32'(vecs[i].e_st));
      end
      chk($sformatf("v%0d_err_stale", i), 32'(err_stale), 32'(vecs[i].e_stale));
      chk($sformatf("v%0d_err_sqhd", i), 32'(err_sqhd), 32'(vecs[i].e_sqhd));
    end
    settle();

    // Three commits with a slow AW channel: final SQ doorbell carries 3.
    do_reset();
    aw_delay = 3;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    settle();
    chk("db3_nwrites_nonzero", 32'(wr_addr.size() > 0), 1);
    if (wr_addr.size() > 0) begin
      chk("db3_last_addr", wr_addr[wr_addr.size()-1], 32'h1008);
      chk("db3_last_data", wr_data[wr_data.size()-1], 32'd3);
      for (int i = 0; i < wr_addr.size(); i++) chk($sformatf("db3_addr%0d", i), wr_addr[i], 32'h1008);
    end
    aw_delay = 0;

    // Fill to 15 entries, stall the 16th, then release with SQHD = 1.
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("full_sq_full", 32'(sq_full), 1);
    chk("full_ready", 32'(sq_commit_ready), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("full_stall_tail", 32'(sq_tail), 15);
    chk("full_stall_inflight", 32'(inflight), 15);
    cyc(0, 1, 1, 16'd1, 16'd0, 15'd0);
    chk("full_release_ready", 32'(sq_commit_ready), 1);
    chk("full_release_head", 32'(sq_head), 1);
    chk("full_release_inflight", 32'(inflight), 14);
    chk("full_release_err_sqhd", 32'(err_sqhd), 0);
    settle();

    // Sixteen completions wrap the CQ and flip the expected phase.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 16'((i + 1) % 16), 16'(i), 15'(i));
      chk($sformatf("wrap_cpl_valid%0d", i), 32'(cpl_valid), 1);
      chk($sformatf("wrap_cpl_cid%0d", i), 32'(cpl_cid), 32'(i));
    end
    cyc(0, 1, 1, 16'd0, 16'hAA, 15'd0);
    chk("wrap_stale_cpl", 32'(cpl_valid), 0);
    chk("wrap_err_stale", 32'(err_stale), 1);
    chk("wrap_inflight", 32'(inflight), 0);
    chk("wrap_err_sqhd", 32'(err_sqhd), 0);
    settle();
    begin
      int last_cq = -1;
      for (int i = 0; i < wr_addr.size(); i++)
        if (wr_addr[i] == 32'h100C) last_cq = i;
      chk("wrap_cq_db_seen", 32'(last_cq >= 0), 1);
      if (last_cq >= 0) chk("wrap_cq_head", wr_data[last_cq], 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 16'd1, 16'h20, 15'd0);
    chk("wrap_phase0_cpl", 32'(cpl_valid), 1);
    chk("wrap_phase0_cid", 32'(cpl_cid), 32'h20);
    settle();

    // Commit and CQE together: both doorbells pending, SQ served first.
    do_reset();
    cyc(1, 1, 1, 16'd0, 16'd5, 15'd0);
    chk("both_inflight", 32'(inflight), 0);
    chk("both_cpl", 32'(cpl_valid), 1);
    settle();
    chk("both_nwrites", 32'(wr_addr.size()), 2);
    if (wr_addr.size() == 2) begin
      chk("both_w0_addr", wr_addr[0], 32'h1008);
      chk("both_w0_data", wr_data[0], 1);
      chk("both_w0_strb", 32'(wr_strb[0]), 32'hF);
      chk("both_w1_addr", wr_addr[1], 32'h100C);
      chk("both_w1_data", wr_data[1], 1);
    end

    // SLVERR response is sticky and the writer keeps working.
    bresp_cfg = 2'b10;
    cyc(1, 0, 0, 0, 0, 0);
    settle();
    chk("bresp_err", 32'(err_bresp), 1);
    bresp_cfg = 2'b00;
    cyc(1, 0, 0, 0, 0, 0);
    settle();
    chk("bresp_sticky", 32'(err_bresp), 1);
    chk("bresp_nwrites", 32'(wr_addr.size()), 4);
    if (wr_addr.size() == 4) chk("bresp_last_data", wr_data[3], 3);

    // Reset while waiting in RESP abandons the write.
    do_reset();
    b_en = 0;
    cyc(1, 0, 0, 0, 0, 0);
    begin
      int n = 0;
      while (!nl_if.nl_bready && n < 50) begin @(posedge clk); #1; n++; end
      chk("rstresp_reached", 32'(nl_if.nl_bready), 1);
    end
    #2;
    rstn = 0;
    #1;
    chk("rstresp_bready", 32'(nl_if.nl_bready), 0);
    chk("rstresp_awvalid", 32'(nl_if.nl_awvalid), 0);
    chk("rstresp_sq_tail", 32'(sq_tail), 0);
    @(negedge clk);
    rstn = 1;
    b_en = 1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 16'd1, 16'd9, 15'd0);
    chk("rstresp_phase1_cpl", 32'(cpl_valid), 1);
    chk("rstresp_phase1_cid", 32'(cpl_cid), 9);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nvme_queue_ctrl.md
NVME_QUEUE_CTRL -- requirements
Module: nvme_queue_ctrl

Interface
REQ-001 Parameter OUTSTANDING, default 16, SQ and CQ depth in entries; power of two.
REQ-002 Parameter QID, default 1, I/O queue pair index used for doorbell addressing.
REQ-003 Parameter DB_BASE, default 32'h1000, doorbell register base in controller BAR0.
REQ-004 Parameter DSTRD, default 0, doorbell stride exponent; stride = 4<<DSTRD bytes.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- sq_commit_valid  in  1  one SQ entry plus its write-buffer data are durable
- sq_commit_ready  out  1  commit accepted
- sq_tail  out  log2(OUTSTANDING)  next free SQ slot, used as CID and buffer index
- sq_head  out  log2(OUTSTANDING)  controller-reported SQ head
- sq_full  out  1  (sq_tail+1) mod OUTSTANDING == sq_head
- inflight  out  log2(OUTSTANDING)+1  commands submitted but not completed
- cqe_valid  in  1  16-byte CQ entry received from NVMe
- cqe_data  in  128  CQ entry: DW2[15:0]=SQHD, DW3[15:0]=CID, DW3[16]=P, DW3[31:17]=status
- cqe_ready  out  1  CQ entry accepted
- cpl_valid  out  1  completion pulse
- cpl_cid  out  16  completed CID
- cpl_status  out  15  completion status
- nl_awaddr, nl_awvalid, nl_awready  out/out/in  32/1/1  AXI-Lite doorbell AW
- nl_wdata, nl_wstrb, nl_wvalid, nl_wready  out/out/out/in  32/4/1/1  AXI-Lite doorbell W
- nl_bresp, nl_bvalid, nl_bready  in/in/out  2/1/1  AXI-Lite doorbell B
- err_stale, err_sqhd, err_bresp  out  1 each  sticky error flags

Function
REQ-006 sq_commit_ready SHALL equal ~sq_full; on commit handshake, sq_tail SHALL increment mod OUTSTANDING and sq_db_pend SHALL be set.
REQ-007 cqe_ready SHALL be 1 whenever out of reset; CQ entries are never backpressured.
REQ-008 An accepted CQE with P == exp_phase SHALL pulse cpl_valid one cycle later with cpl_cid and cpl_status, advance cq_head mod OUTSTANDING, set cq_db_pend, and load sq_head from SQHD[log2(OUTSTANDING)-1:0].
REQ-009 exp_phase SHALL reset to 1 and SHALL toggle when cq_head wraps from OUTSTANDING-1 to 0.
REQ-010 An accepted CQE with P != exp_phase SHALL be discarded with no state change and SHALL set err_stale.
REQ-011 A SQHD value outside the circular window [sq_head, sq_tail] SHALL set err_sqhd and still be applied.
REQ-012 inflight SHALL increment on commit, decrement on valid CQE, and remain unchanged when both occur in the same cycle.
REQ-013 Doorbell FSM states: IDLE, ISSUE, RESP.
REQ-014 IDLE: if either pend flag is set, select a doorbell and go to ISSUE; if both are set, select the type not served last (first ever: SQ).
REQ-015 On selection, the block SHALL clear that pend flag and latch the value: SQ writes sq_tail to DB_BASE+(2*QID)*stride; CQ writes cq_head to DB_BASE+(2*QID+1)*stride; wdata is zero-extended; wstrb = 4'hF.
REQ-016 ISSUE: nl_awvalid and nl_wvalid SHALL assert together and each SHALL drop independently after its own handshake; go to RESP once both have completed, including same-cycle completion.
REQ-017 RESP: nl_bready = 1; on nl_bvalid go to IDLE and set err_bresp if nl_bresp != 0.
REQ-018 Events arriving during ISSUE/RESP SHALL re-set the pend flag; multiple events SHALL coalesce into one write carrying the latest value at selection.
REQ-019 AW/W payload SHALL be stable while valid is high.

Reset
REQ-020 On rstn low: all pointers, inflight, pend flags, errors, cpl_valid, nl_awvalid, nl_wvalid, nl_bready = 0; exp_phase = 1; FSM = IDLE; last-served = CQ.
REQ-021 Reset mid-transaction SHALL abandon it immediately; no outstanding-write recovery.

Structure
REQ-022 Package nvme_drv_pkg SHALL hold OUTSTANDING, DB_BASE, DSTRD, CQE field offsets, and the doorbell FSM enum.
REQ-023 The AW/W/B sequencing SHALL live in sub-module nvme_db_axil_writer (one write at a time: start/addr/data in, done/err out).

Verification
REQ-024 Three commits, awready delayed 3 cycles -> one SQ doorbell write to 0x1008, wdata = 3 (coalesced or sequential, final value 3).
REQ-025 Fifteen commits without completion -> sq_full = 1, sq_commit_ready = 0, 16th commit stalls; one valid CQE with SQHD = 1 -> sq_commit_ready = 1.
REQ-026 Sixteen valid CQEs with P = 1, then a CQE with P = 1 -> exp_phase = 0, cq_head = 0, err_stale = 1, no cpl_valid pulse.
REQ-027 Commit and CQE in the same cycle with both doorbells pending -> SQ write to 0x1008, then CQ write to 0x100C, inflight unchanged.
REQ-028 Doorbell returns nl_bresp = 2'b10 -> err_bresp = 1 (sticky), FSM returns to IDLE.
REQ-029 rstn asserted during RESP -> next cycle nl_bready = 0, sq_tail = 0, exp_phase = 1.
